sala_de_controle: RTL and testbench
===================================

Name: sala_de_controle

Overview:
Nuclear-plant control-room alarm block. It compares three sensor readings (temperature, pressure, radiation) against fixed limits and drives the audible alarm immediately, with no clock latency, when any limit is exceeded. It also keeps sticky per-cause flags, which an operator acknowledge clears, and a saturating count of alarm events. It sits between the sensor-acquisition logic and the control-room annunciator/operator panel.

Parameters:
TEMP_LIMIT, 40, temperature threshold; over-limit when temp > TEMP_LIMIT (unsigned)
PRESS_LIMIT, 12, pressure threshold; over-limit when pressao > PRESS_LIMIT
RAD_LIMIT, 2000, radiation threshold; over-limit when radiacao > RAD_LIMIT
CNT_W, 8, width of alarm event counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
temp  in  8  temperature reading, unsigned
pressao  in  4  pressure reading, unsigned
radiacao  in  12  radiation reading, unsigned
ack  in  1  operator acknowledge; clears sticky flags
alarmeSonoroSC  out  1  audible alarm, combinational OR of over-limit conditions
causa  out  3  live causes {rad, press, temp}, combinational
causa_latched  out  3  sticky causes {rad, press, temp}, registered
alarm_count  out  CNT_W  number of alarm rising edges, saturating

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- All comparisons are unsigned strict greater-than. A value equal to its limit does not alarm.
- causa[0] = temp > TEMP_LIMIT; causa[1] = pressao > PRESS_LIMIT; causa[2] = radiacao > RAD_LIMIT.
- alarmeSonoroSC = |causa. Purely combinational, zero latency, valid while in reset and independent of clk/ack. An X/Z input must not be masked. Simulation treats an unknown input as unknown.
- causa_latched: register, reset value 3'b000. Each cycle: causa_latched <= (ack ? 3'b000 : causa_latched) | causa. If ack is high while a cause is still live, that bit stays set because set wins over clear.
- alarm_count: reset value 0. It increments by 1 on each cycle where alarmeSonoroSC is 1 and its registered previous value (alarm_q, reset 0) is 0, i.e. on a rising edge of the alarm. It saturates at 2^CNT_W-1 and never wraps. ack does not clear it; only rst_n does.
- Reset mid-operation: registered outputs clear asynchronously at once. Combinational outputs continue to follow the inputs. After reset is released, a still-high alarm counts as a new rising edge on the first clock.
- Simultaneous causes: all relevant causa bits are set together, and they count as a single event.

Decomposition:
- Package sala_de_controle_pkg: width constants TEMP_W=8, PRESS_W=4, RAD_W=12, CNT_W=8; default limits; cause bit indices (CAUSA_TEMP=0, CAUSA_PRESS=1, CAUSA_RAD=2).
- One sub-module, limite_sensor, parameterised by WIDTH and LIMIT. Output over = value > LIMIT. It is instantiated three times in the top module.
- The top module holds the OR, the sticky register, the edge detector and the saturating counter.

Test Plan:
- pressao=0, radiacao=0, temp swept 0..100 in steps of 2 -> alarmeSonoroSC=0 for temp<=40, =1 for temp>=42; causa=3'b001 when set.
- temp=40, pressao=12, radiacao=2000 (all at limit) -> alarmeSonoroSC=0, causa=0; then temp=41 -> alarmeSonoroSC=1 in the same delta, with no clock edge needed.
- temp=0, pressao=13 -> causa=3'b010; radiacao=2001 also -> causa=3'b110, alarm=1, alarm_count increments by exactly 1.
- Raise temp=50 for 3 cycles, then temp=0 -> causa_latched stays 3'b001. Pulse ack for 1 cycle -> 3'b000 next cycle. ack held while temp=50 -> remains 3'b001.
- Toggle alarm on/off 300 times -> alarm_count saturates at 255.
- Assert rst_n=0 asynchronously between clock edges with temp=60 -> causa_latched=0 and alarm_count=0 immediately, while alarmeSonoroSC stays 1. After release -> count=1 after the first clk edge.

Source files
------------

// File: rtl/sala_de_controle_pkg.sv
// ============================================================================
// sala_de_controle_pkg : shared widths, default limits and cause bit indices
// Revision: 1.0
// ============================================================================
`default_nettype none

package sala_de_controle_pkg;

  localparam int unsigned TEMP_W  = 8;
  localparam int unsigned PRESS_W = 4;
  localparam int unsigned RAD_W   = 12;
  localparam int unsigned CNT_W   = 8;

  localparam int unsigned TEMP_LIMIT_DEF  = 40;
  localparam int unsigned PRESS_LIMIT_DEF = 12;
  localparam int unsigned RAD_LIMIT_DEF   = 2000;

  localparam int unsigned CAUSA_TEMP  = 0;
  localparam int unsigned CAUSA_PRESS = 1;
  localparam int unsigned CAUSA_RAD   = 2;
  localparam int unsigned CAUSA_W     = 3;

  typedef logic [CAUSA_W-1:0] causa_t;

endpackage

`default_nettype wire

// File: rtl/sala_de_controle_limite_sensor.sv
// ============================================================================
// limite_sensor : unsigned strict over-limit comparator for one sensor reading
// Revision: 1.0
// ============================================================================
`default_nettype none

module limite_sensor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 40
) (
  input  logic [WIDTH-1:0] value,
  output logic             over
);

  // Compare at 33 bits so a LIMIT wider than the reading can never truncate.
  logic [32:0] value_ext;
  logic [32:0] limit_ext;

  assign value_ext = {{(33-WIDTH){1'b0}}, value};
  assign limit_ext = {1'b0, LIMIT};
  assign over      = value_ext > limit_ext;

endmodule

`default_nettype wire

// File: rtl/sala_de_controle.sv
// ============================================================================
// sala_de_controle : control-room alarm with live/sticky causes and event count
// Revision: 1.0
// ============================================================================
`default_nettype none

module sala_de_controle
  import sala_de_controle_pkg::*;
#(
  parameter int unsigned TEMP_LIMIT  = TEMP_LIMIT_DEF,
  parameter int unsigned PRESS_LIMIT = PRESS_LIMIT_DEF,
  parameter int unsigned RAD_LIMIT   = RAD_LIMIT_DEF,
  parameter int unsigned CNT_W       = sala_de_controle_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TEMP_W-1:0]  temp,
  input  logic [PRESS_W-1:0] pressao,
  input  logic [RAD_W-1:0]   radiacao,
  input  logic               ack,
  output logic               alarmeSonoroSC,
  output causa_t             causa,
  output causa_t             causa_latched,
  output logic [CNT_W-1:0]   alarm_count
);

  limite_sensor #(.WIDTH(TEMP_W), .LIMIT(TEMP_LIMIT)) u_lim_temp (
    .value (temp),
    .over  (causa[CAUSA_TEMP])
  );

  limite_sensor #(.WIDTH(PRESS_W), .LIMIT(PRESS_LIMIT)) u_lim_press (
    .value (pressao),
    .over  (causa[CAUSA_PRESS])
  );

  limite_sensor #(.WIDTH(RAD_W), .LIMIT(RAD_LIMIT)) u_lim_rad (
    .value (radiacao),
    .over  (causa[CAUSA_RAD])
  );

  assign alarmeSonoroSC = |causa;

  causa_t           causa_latched_q, causa_latched_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] alarm_count_q, alarm_count_d;

  always_comb begin
    // A live cause re-sets its bit even while ack clears the rest.
    causa_latched_d = (ack ? '0 : causa_latched_q) | causa;
    alarm_d         = alarmeSonoroSC;
    alarm_count_d   = alarm_count_q;
    if (alarmeSonoroSC && !alarm_q && (alarm_count_q != '1)) begin
      alarm_count_d = alarm_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      causa_latched_q <= '0;
      alarm_q         <= 1'b0;
      alarm_count_q   <= '0;
    end else begin
      causa_latched_q <= causa_latched_d;
      alarm_q         <= alarm_d;
      alarm_count_q   <= alarm_count_d;
    end
  end

  assign causa_latched = causa_latched_q;
  assign alarm_count   = alarm_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sala_de_controle.sv
// ============================================================================
// tb_sala_de_controle : directed + random checks against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sala_de_controle;

  logic        clk;
  logic        rst_n;
  logic [7:0]  temp;
  logic [3:0]  pressao;
  logic [11:0] radiacao;
  logic        ack;
  logic        alarmeSonoroSC;
  logic [2:0]  causa;
  logic [2:0]  causa_latched;
  logic [7:0]  alarm_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: which causes have been seen since the last ack, the
  // alarm level seen at the previous clock, and the number of alarm events.
  bit m_seen_temp, m_seen_press, m_seen_rad;
  bit m_prev_alarm;
  int m_events;

  sala_de_controle dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .temp           (temp),
    .pressao        (pressao),
    .radiacao       (radiacao),
    .ack            (ack),
    .alarmeSonoroSC (alarmeSonoroSC),
    .causa          (causa),
    .causa_latched  (causa_latched),
    .alarm_count    (alarm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit hot_temp();
    return int'(temp) > 40;
  endfunction
  function automatic bit hot_press();
    return int'(pressao) > 12;
  endfunction
  function automatic bit hot_rad();
    return int'(radiacao) > 2000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    bit any;
    any = hot_temp() || hot_press() || hot_rad();
    chk({tag, "_causa"}, {29'd0, causa}, {29'd0, hot_rad(), hot_press(), hot_temp()});
    chk({tag, "_alarm"}, {31'd0, alarmeSonoroSC}, {31'd0, any});
  endtask

  task automatic set_in(input logic [7:0] t, input logic [3:0] p, input logic [11:0] r,
                        input logic a);
    temp = t; pressao = p; radiacao = r; ack = a;
    #1;
  endtask

  task automatic model_reset();
    m_seen_temp = 0; m_seen_press = 0; m_seen_rad = 0;
    m_prev_alarm = 0; m_events = 0;
  endtask

  // Advance the reference by one clock using the inputs present at the edge,
  // then compare the registered outputs just after that edge.
  task automatic cycle(input string tag);
    bit now_alarm;
    now_alarm = hot_temp() || hot_press() || hot_rad();
    if (ack) begin
      m_seen_temp = 0; m_seen_press = 0; m_seen_rad = 0;
    end
    if (hot_temp())  m_seen_temp  = 1;
    if (hot_press()) m_seen_press = 1;
    if (hot_rad())   m_seen_rad   = 1;
    if (now_alarm && !m_prev_alarm && m_events < 255) m_events++;
    m_prev_alarm = now_alarm;
    @(posedge clk);
    #1;
    chk({tag, "_latched"}, {29'd0, causa_latched}, {29'd0, m_seen_rad, m_seen_press, m_seen_temp});
    chk({tag, "_count"}, {24'd0, alarm_count}, m_events);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(8'd0, 4'd0, 12'd0, 1'b0);
    model_reset();
    chk("reset_latched", {29'd0, causa_latched}, 32'd0);
    chk("reset_count", {24'd0, alarm_count}, 32'd0);
    chk_comb("reset_idle");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("idle");

    // Temperature sweep across its limit.
    for (int t = 0; t <= 100; t += 2) begin
      set_in(8'(t), 4'd0, 12'd0, 1'b0);
      chk_comb("sweep");
      if (t == 40) chk("sweep_40", {31'd0, alarmeSonoroSC}, 32'd0);
      if (t == 42) chk("sweep_42", {29'd0, causa}, 32'd1);
      cycle("sweep");
    end

    // All exactly at limit, then one step over with no clock edge.
    set_in(8'd40, 4'd12, 12'd2000, 1'b0);
    chk("at_limit_alarm", {31'd0, alarmeSonoroSC}, 32'd0);
    chk("at_limit_causa", {29'd0, causa}, 32'd0);
    temp = 8'd41;
    #0;
    chk("limit_plus1_alarm", {31'd0, alarmeSonoroSC}, 32'd1);
    chk_comb("limit_plus1");
    cycle("limit_plus1");
    set_in(8'd0, 4'd0, 12'd0, 1'b1);
    cycle("clear1");
    set_in(8'd0, 4'd0, 12'd0, 1'b0);
    cycle("quiet1");

    // Pressure alone, then radiation joins: one event only.
    set_in(8'd0, 4'd13, 12'd0, 1'b0);
    chk("press_causa", {29'd0, causa}, 32'd2);
    cycle("press");
    set_in(8'd0, 4'd13, 12'd2001, 1'b0);
    chk("press_rad_causa", {29'd0, causa}, 32'd6);
    cycle("press_rad");
    set_in(8'd0, 4'd0, 12'd0, 1'b1);
    cycle("clear2");

    // Sticky flag, ack clear, ack held against a live cause.
    set_in(8'd50, 4'd0, 12'd0, 1'b0);
    repeat (3) cycle("temp_hot");
    set_in(8'd0, 4'd0, 12'd0, 1'b0);
    cycle("temp_gone");
    chk("sticky_hold", {29'd0, causa_latched}, 32'd1);
    set_in(8'd0, 4'd0, 12'd0, 1'b1);
    cycle("ack_pulse");
    chk("ack_cleared", {29'd0, causa_latched}, 32'd0);
    set_in(8'd50, 4'd0, 12'd0, 1'b1);
    repeat (2) cycle("ack_vs_live");
    chk("set_wins", {29'd0, causa_latched}, 32'd1);

    // Unknown input must reach the alarm as unknown (no clock edge meanwhile).
    set_in(8'd0, 4'd0, 12'd0, 1'b0);
    temp = 8'bx;
    #1;
    chk("x_alarm", {31'd0, alarmeSonoroSC}, {31'd0, 1'bx});
    set_in(8'd0, 4'd0, 12'd0, 1'b0);
    cycle("after_x");

    // Randomised traffic around the limits.
    for (int i = 0; i < 200; i++) begin
      set_in(8'($urandom_range(30, 50)), 4'($urandom_range(10, 15)),
             12'($urandom_range(1990, 2010)), 1'($urandom_range(0, 3) == 0));
      chk_comb("rand");
      cycle("rand");
    end

    // Saturation of the event counter.
    for (int i = 0; i < 300; i++) begin
      set_in(8'd50, 4'd0, 12'd0, 1'b0);
      cycle("sat_on");
      set_in(8'd0, 4'd0, 12'd0, 1'b0);
      cycle("sat_off");
    end
    chk("saturated", {24'd0, alarm_count}, 32'd255);

    // Asynchronous reset between edges while the alarm is live.
    set_in(8'd60, 4'd0, 12'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_latched", {29'd0, causa_latched}, 32'd0);
    chk("async_rst_count", {24'd0, alarm_count}, 32'd0);
    chk("async_rst_alarm", {31'd0, alarmeSonoroSC}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst");
    chk("post_rst_count1", {24'd0, alarm_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
